// File: rtl/wild_encounter_ctrl.sv
// Wild encounter controller: rolls an 8-bit Galois LFSR on grass steps,
// latches the opponent, runs the screen-flash transition, holds the battle
// and applies a grass-step cooldown before encounters re-arm.
module wild_encounter_ctrl #(
    parameter logic [8:0] ENC_THRESH     = 9'd40,
    parameter int         FLASH_FRAMES   = 60,
    parameter int         COOLDOWN_STEPS = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       frameClk,
    input  logic       Reset,
    input  logic [1:0] curr_map,
    input  logic       step,
    input  logic       in_grass,
    input  logic [4:0] wild_ID,
    input  logic       battle_done,
    output logic       fight_on,
    output logic [4:0] enemy_ID,
    output logic       transition_active,
    output logic       flash_on,
    output logic [7:0] encounter_count,
    output logic [1:0] state_dbg,
    output logic [7:0] lfsr_dbg
);

    typedef enum logic [1:0] {
        ROAM     = 2'd0,
        FLASH    = 2'd1,
        BATTLE   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [3:0] CD_INIT    = 4'(COOLDOWN_STEPS);

    state_t     state, state_d;
    logic [7:0] lfsr, lfsr_nxt;
    logic [7:0] flash_cnt, flash_cnt_d;
    logic [3:0] cd_cnt, cd_cnt_d;
    logic       hit;
    logic       grass_step;
    logic       roll_hit;
    logic       fight_d, trans_d, flash_d;

    // The map is not used for gating; any map permits encounters.
    logic map_unused;
    assign map_unused = ^curr_map;

    assign grass_step = step & in_grass;
    assign roll_hit   = ({1'b0, lfsr} < ENC_THRESH);
    assign lfsr_nxt   = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

    assign state_dbg  = state;
    assign lfsr_dbg   = lfsr;

    // State register plus datapath registers; outputs are registered from next-state values.
    always_ff @(posedge frameClk) begin
        if (Reset) begin
            state             <= ROAM;
            lfsr              <= LFSR_SEED;
            flash_cnt         <= 8'd0;
            cd_cnt            <= 4'd0;
            fight_on          <= 1'b0;
            enemy_ID          <= 5'b00000;
            transition_active <= 1'b0;
            flash_on          <= 1'b0;
            encounter_count   <= 8'd0;
        end else begin
            state             <= state_d;
            lfsr              <= lfsr_nxt;
            flash_cnt         <= flash_cnt_d;
            cd_cnt            <= cd_cnt_d;
            fight_on          <= fight_d;
            transition_active <= trans_d;
            flash_on          <= flash_d;
            if (hit) begin
                enemy_ID <= wild_ID;
                if (encounter_count != 8'hFF) begin
                    encounter_count <= encounter_count + 8'd1;
                end
            end
        end
    end

    // Next-state logic: roll in ROAM, count frames in FLASH, wait for battle end, count down grass steps.
    always_comb begin
        state_d     = state;
        flash_cnt_d = flash_cnt;
        cd_cnt_d    = cd_cnt;
        hit         = 1'b0;
        case (state)
            ROAM: begin
                if (grass_step && roll_hit) begin
                    hit         = 1'b1;
                    flash_cnt_d = 8'd0;
                    state_d     = FLASH;
                end
            end
            FLASH: begin
                if (flash_cnt == FLASH_LAST) begin
                    flash_cnt_d = 8'd0;
                    state_d     = BATTLE;
                end else begin
                    flash_cnt_d = flash_cnt + 8'd1;
                end
            end
            BATTLE: begin
                // battle_done wins over a simultaneous step; that step is not counted.
                if (battle_done) begin
                    if (CD_INIT == 4'd0) begin
                        state_d = ROAM;
                    end else begin
                        cd_cnt_d = CD_INIT;
                        state_d  = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                // The step that finishes the cooldown only re-arms; it never rolls.
                if (grass_step) begin
                    if (cd_cnt <= 4'd1) begin
                        cd_cnt_d = 4'd0;
                        state_d  = ROAM;
                    end else begin
                        cd_cnt_d = cd_cnt - 4'd1;
                    end
                end
            end
            default: state_d = ROAM;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        fight_d = (state_d == BATTLE);
        trans_d = (state_d == FLASH);
        flash_d = trans_d & flash_cnt_d[3];
    end

endmodule

// File: tb/tb_wild_encounter_ctrl.sv
// Bench for wild_encounter_ctrl: several parameterisations share one input
// bus; each scenario resets first and checks only the instance it targets.
module tb_wild_encounter_ctrl;

    logic       frameClk = 1'b0;
    logic       Reset    = 1'b1;
    logic [1:0] curr_map = 2'd0;
    logic       step     = 1'b0;
    logic       in_grass = 1'b0;
    logic [4:0] wild_ID  = 5'd0;
    logic       battle_done = 1'b0;

    // Instance A: always-hit, short flash, cooldown 3
    logic       fight_a, trans_a, flash_a;
    logic [4:0] enemy_a;
    logic [7:0] count_a, lfsr_a;
    logic [1:0] state_a;
    // Instance B: never-hit
    logic       fight_b, trans_b, flash_b;
    logic [4:0] enemy_b;
    logic [7:0] count_b, lfsr_b;
    logic [1:0] state_b;
    // Instance C: always-hit, default 60-frame flash
    logic       fight_c, trans_c, flash_c;
    logic [4:0] enemy_c;
    logic [7:0] count_c, lfsr_c;
    logic [1:0] state_c;
    // Instance D: always-hit, 1-frame flash, no cooldown
    logic       fight_d, trans_d, flash_d;
    logic [4:0] enemy_d;
    logic [7:0] count_d, lfsr_d;
    logic [1:0] state_d;
    // Instance E: default parameters (real roll)
    logic       fight_e, trans_e, flash_e;
    logic [4:0] enemy_e;
    logic [7:0] count_e, lfsr_e;
    logic [1:0] state_e;

    wild_encounter_ctrl #(.ENC_THRESH(9'd256), .FLASH_FRAMES(4), .COOLDOWN_STEPS(3)) u_a (
        .frameClk(frameClk), .Reset(Reset), .curr_map(curr_map), .step(step), .in_grass(in_grass),
        .wild_ID(wild_ID), .battle_done(battle_done), .fight_on(fight_a), .enemy_ID(enemy_a),
        .transition_active(trans_a), .flash_on(flash_a), .encounter_count(count_a),
        .state_dbg(state_a), .lfsr_dbg(lfsr_a));
    wild_encounter_ctrl #(.ENC_THRESH(9'd0), .FLASH_FRAMES(4), .COOLDOWN_STEPS(3)) u_b (
        .frameClk(frameClk), .Reset(Reset), .curr_map(curr_map), .step(step), .in_grass(in_grass),
        .wild_ID(wild_ID), .battle_done(battle_done), .fight_on(fight_b), .enemy_ID(enemy_b),
        .transition_active(trans_b), .flash_on(flash_b), .encounter_count(count_b),
        .state_dbg(state_b), .lfsr_dbg(lfsr_b));
    wild_encounter_ctrl #(.ENC_THRESH(9'd256), .FLASH_FRAMES(60), .COOLDOWN_STEPS(3)) u_c (
        .frameClk(frameClk), .Reset(Reset), .curr_map(curr_map), .step(step), .in_grass(in_grass),
        .wild_ID(wild_ID), .battle_done(battle_done), .fight_on(fight_c), .enemy_ID(enemy_c),
        .transition_active(trans_c), .flash_on(flash_c), .encounter_count(count_c),
        .state_dbg(state_c), .lfsr_dbg(lfsr_c));
    wild_encounter_ctrl #(.ENC_THRESH(9'd256), .FLASH_FRAMES(1), .COOLDOWN_STEPS(0)) u_d (
        .frameClk(frameClk), .Reset(Reset), .curr_map(curr_map), .step(step), .in_grass(in_grass),
        .wild_ID(wild_ID), .battle_done(battle_done), .fight_on(fight_d), .enemy_ID(enemy_d),
        .transition_active(trans_d), .flash_on(flash_d), .encounter_count(count_d),
        .state_dbg(state_d), .lfsr_dbg(lfsr_d));
    wild_encounter_ctrl u_e (
        .frameClk(frameClk), .Reset(Reset), .curr_map(curr_map), .step(step), .in_grass(in_grass),
        .wild_ID(wild_ID), .battle_done(battle_done), .fight_on(fight_e), .enemy_ID(enemy_e),
        .transition_active(trans_e), .flash_on(flash_e), .encounter_count(count_e),
        .state_dbg(state_e), .lfsr_dbg(lfsr_e));

    // Clock
    always #5 frameClk = ~frameClk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       s;
        logic       g;
        logic [4:0] w;
        logic       bd;
        logic       exp_fight;
        logic       exp_trans;
        logic [4:0] exp_enemy;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic g, input logic [4:0] w, input logic bd,
                                input logic ef, input logic et, input logic [4:0] ee, input logic [7:0] ec);
        vec_t v;
        v.s = s; v.g = g; v.w = w; v.bd = bd;
        v.exp_fight = ef; v.exp_trans = et; v.exp_enemy = ee; v.exp_count = ec;
        vecs.push_back(v);
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        logic [7:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, return 1 time unit after it.
    task automatic drive(input logic s, input logic g, input logic [4:0] w, input logic bd);
        step = s; in_grass = g; wild_ID = w; battle_done = bd;
        @(posedge frameClk);
        #1;
    endtask

    task automatic do_reset();
        step = 1'b0; in_grass = 1'b0; battle_done = 1'b0;
        Reset = 1'b1;
        @(posedge frameClk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        logic       hit_seen;

        // Encounter, flash, battle, cooldown on instance A
        add(0, 0, 5'h00, 0,  0, 0, 5'h00, 8'd0);
        add(0, 1, 5'h03, 0,  0, 0, 5'h00, 8'd0);
        add(1, 0, 5'h0D, 0,  0, 0, 5'h00, 8'd0);
        add(1, 1, 5'h0D, 0,  0, 1, 5'h0D, 8'd1);
        add(0, 0, 5'h1F, 1,  0, 1, 5'h0D, 8'd1);
        add(1, 1, 5'h02, 0,  0, 1, 5'h0D, 8'd1);
        add(0, 0, 5'h00, 0,  0, 1, 5'h0D, 8'd1);
        add(0, 0, 5'h00, 0,  1, 0, 5'h0D, 8'd1);
        add(1, 1, 5'h07, 0,  1, 0, 5'h0D, 8'd1);
        add(1, 1, 5'h07, 1,  0, 0, 5'h0D, 8'd1);
        add(1, 1, 5'h07, 0,  0, 0, 5'h0D, 8'd1);
        add(1, 0, 5'h07, 0,  0, 0, 5'h0D, 8'd1);
        add(1, 1, 5'h07, 0,  0, 0, 5'h0D, 8'd1);
        add(1, 1, 5'h07, 0,  0, 0, 5'h0D, 8'd1);
        add(1, 1, 5'h15, 0,  0, 1, 5'h15, 8'd2);
        add(0, 0, 5'h00, 0,  0, 1, 5'h15, 8'd2);
        add(0, 0, 5'h00, 1,  0, 1, 5'h15, 8'd2);
        add(0, 0, 5'h00, 0,  0, 1, 5'h15, 8'd2);
        add(0, 0, 5'h00, 0,  1, 0, 5'h15, 8'd2);

        do_reset();
        check("a_reset_fight", fight_a, 0);
        check("a_reset_enemy", enemy_a, 0);
        check("a_reset_count", count_a, 0);
        check("a_reset_state", state_a, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s, vecs[i].g, vecs[i].w, vecs[i].bd);
            check($sformatf("a_vec%0d_fight", i), fight_a, vecs[i].exp_fight);
            check($sformatf("a_vec%0d_trans", i), trans_a, vecs[i].exp_trans);
            check($sformatf("a_vec%0d_flash", i), flash_a, 0);
            check($sformatf("a_vec%0d_enemy", i), enemy_a, vecs[i].exp_enemy);
            check($sformatf("a_vec%0d_count", i), count_a, vecs[i].exp_count);
        end

        // Reset in the middle of a battle, then LFSR restart against the model
        check("a_in_battle", state_a, 2);
        do_reset();
        check("a_rst_fight", fight_a, 0);
        check("a_rst_trans", trans_a, 0);
        check("a_rst_flash", flash_a, 0);
        check("a_rst_enemy", enemy_a, 0);
        check("a_rst_count", count_a, 0);
        check("a_rst_state", state_a, 0);
        m = 8'hA5;
        check("a_lfsr_seed", lfsr_a, m);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 5'h00, 0);
            m = lfsr_adv(m);
            check($sformatf("a_lfsr%0d", i), lfsr_a, m);
        end

        // Threshold 0 never encounters
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive(1, 1, 5'(i), 0);
            check("b_no_trans", trans_b, 0);
        end
        check("b_fight", fight_b, 0);
        check("b_count", count_b, 0);

        // 60-frame flash strobe; inputs ignored during the transition
        do_reset();
        drive(1, 1, 5'h0A, 0);
        check("c_enemy", enemy_c, 5'h0A);
        check("c_trans0", trans_c, 1);
        check("c_flash0", flash_c, 0);
        for (int k = 1; k < 60; k++) begin
            drive(1'(k & 1), 1, 5'(k), 1'(k % 7 == 0));
            check($sformatf("c_trans%0d", k), trans_c, 1);
            check($sformatf("c_flash%0d", k), flash_c, (k >> 3) & 1);
            check($sformatf("c_enemy%0d", k), enemy_c, 5'h0A);
            check($sformatf("c_state%0d", k), state_c, 1);
            check($sformatf("c_fight%0d", k), fight_c, 0);
        end
        drive(0, 0, 5'h00, 0);
        check("c_fight_on", fight_c, 1);
        check("c_trans_off", trans_c, 0);
        check("c_flash_off", flash_c, 0);
        check("c_count", count_c, 1);

        // Default threshold: first hit predicted by the LFSR model
        do_reset();
        m = 8'hA5;
        hit_seen = 1'b0;
        for (int i = 0; i < 300 && !hit_seen; i++) begin
            hit_seen = (m < 8'd40);
            drive(1, 1, 5'(i + 3), 0);
            check($sformatf("e_trans%0d", i), trans_e, hit_seen);
            if (hit_seen) begin
                check("e_enemy", enemy_e, 5'(i + 3));
                check("e_count", count_e, 1);
            end
            m = lfsr_adv(m);
        end

        // Saturation of the encounter counter
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            drive(1, 1, 5'(n), 0);
            drive(0, 0, 5'(n), 0);
            if (n == 1) check("d_fight", fight_d, 1);
            drive(0, 0, 5'(n), 1);
            if (n == 100) check("d_count100", count_d, 100);
            if (n == 255) check("d_count255", count_d, 255);
        end
        check("d_count_sat", count_d, 255);
        check("d_enemy", enemy_d, 5'(260));
        check("d_state", state_d, 0);
        check("d_fight_end", fight_d, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
